// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by the arbiter and its users.
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int AW = 6
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          if_err;

    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wd;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wd, mem_rd,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wd
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wd, mem_rd,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported segmented memory: data has priority,
// a starvation counter forces fetch through, responses return one cycle after grant.
module mem_arbiter #(
    parameter int          AW           = 6,
    parameter logic [31:0] DATA_BASE    = 32'd32,
    parameter int          STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int            CW     = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT  = CW'(STARVE_LIMIT);
    // Compared at 33 bits so a large d_addr is never truncated into range.
    localparam logic [32:0]   D_SPAN = (33'd1 << AW) - {1'b0, DATA_BASE};

    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
    logic          if_rvalid_reg, if_err_reg;
    logic          d_rvalid_reg, d_err_reg, d_rd_reg;

    logic          starved;
    logic          if_gnt, d_gnt;
    logic          if_legal, d_legal;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;

    always_comb begin
        starved  = (starve_cnt_reg == LIMIT);
        if_legal = (bus.if_addr < DATA_BASE);
        d_legal  = ({1'b0, bus.d_addr} < D_SPAN);
        if_gnt   = rst_n && bus.if_req && (!bus.d_req || starved);
        d_gnt    = rst_n && bus.d_req && !(bus.if_req && starved);
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (if_gnt && if_legal) begin
            mem_en   = 1'b1;
            mem_addr = bus.if_addr[AW-1:0];
        end else if (d_gnt && d_legal) begin
            mem_en   = 1'b1;
            mem_we   = bus.d_we;
            mem_addr = AW'(DATA_BASE + bus.d_addr);
            mem_wd   = bus.d_wd;
        end
    end

    // Counts data grants while fetch waits; any fetch grant or idle fetch resets it.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (if_gnt || !bus.if_req) begin
            starve_cnt_next = '0;
        end else if (d_gnt && !starved) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
            if_rvalid_reg  <= 1'b0;
            if_err_reg     <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            d_err_reg      <= 1'b0;
            d_rd_reg       <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            if_rvalid_reg  <= if_gnt;
            if_err_reg     <= if_gnt && !if_legal;
            d_rvalid_reg   <= d_gnt;
            d_err_reg      <= d_gnt && !d_legal;
            d_rd_reg       <= d_gnt && !bus.d_we;
        end
    end

    // Responses are masked while reset is asserted so an in-flight one is dropped.
    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = rst_n && if_rvalid_reg;
    assign bus.if_err    = rst_n && if_err_reg;
    assign bus.if_rdata  = (rst_n && if_rvalid_reg && !if_err_reg) ? bus.mem_rd : 32'd0;
    assign bus.d_rvalid  = rst_n && d_rvalid_reg;
    assign bus.d_err     = rst_n && d_err_reg;
    assign bus.d_rdata   = (rst_n && d_rvalid_reg && !d_err_reg && d_rd_reg) ? bus.mem_rd : 32'd0;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wd    = mem_wd;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a registered-read memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam logic [31:0] PAT = 32'hA000_0000;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    typedef struct {
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wd;
        logic        if_gnt;
        logic        d_gnt;
        logic        mem_en;
        logic        mem_we;
        logic [5:0]  mem_addr;
        logic [31:0] mem_wd;
        logic        if_rvalid;
        logic        if_err;
        logic [31:0] if_rdata;
        logic        d_rvalid;
        logic        d_err;
        logic [31:0] d_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(6)) bus ();

    mem_arbiter #(.AW(6), .DATA_BASE(32'd32), .STARVE_LIMIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: word i preset to PAT|i except word 5; registered read.
    logic [31:0] mem [64];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= PAT | 32'(i);
            mem[5]   <= BEEF;
            mem_init <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wd;
            bus.mem_rd <= 32'hBAD0_BAD0;
        end else if (bus.mem_en) begin
            bus.mem_rd <= mem[bus.mem_addr];
        end else begin
            bus.mem_rd <= 32'hBAD0_BAD0;
        end
    end

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic ig, input logic dg, input logic men, input logic mwe,
        input logic [5:0] maddr, input logic [31:0] mwd,
        input logic irv, input logic ierr, input logic [31:0] ird,
        input logic drv, input logic derr, input logic [31:0] drd);
        vec_t v;
        v.rst_n = rst; v.if_req = ir; v.if_addr = ia;
        v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wd = dwd;
        v.if_gnt = ig; v.d_gnt = dg; v.mem_en = men; v.mem_we = mwe;
        v.mem_addr = maddr; v.mem_wd = mwd;
        v.if_rvalid = irv; v.if_err = ierr; v.if_rdata = ird;
        v.d_rvalid = drv; v.d_err = derr; v.d_rdata = drd;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h, want %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n       = v.rst_n;
        bus.if_req  = v.if_req;
        bus.if_addr = v.if_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_addr  = v.d_addr;
        bus.d_wd    = v.d_wd;
    endtask

    function automatic logic [31:0] word_at(input int a);
        return (a == 5) ? BEEF : (PAT | 32'(a));
    endfunction

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wd = '0;

        // reset held with both requesting
        vecs.push_back(mk(0,1,5, 1,0,0,0,            0,0,0,0,0,0,  0,0,0,        0,0,0));
        vecs.push_back(mk(0,1,5, 1,0,0,0,            0,0,0,0,0,0,  0,0,0,        0,0,0));
        // 12-cycle contention: D,D,D,I repeated
        vecs.push_back(mk(1,1,5, 1,0,0,0,            0,1,1,0,32,0, 0,0,0,        0,0,0));
        vecs.push_back(mk(1,1,5, 1,0,1,0,            0,1,1,0,33,0, 0,0,0,        1,0,PAT+32));
        vecs.push_back(mk(1,1,5, 1,0,2,0,            0,1,1,0,34,0, 0,0,0,        1,0,PAT+33));
        vecs.push_back(mk(1,1,5, 1,0,3,0,            1,0,1,0,5,0,  0,0,0,        1,0,PAT+34));
        vecs.push_back(mk(1,1,5, 1,0,3,0,            0,1,1,0,35,0, 1,0,BEEF,     0,0,0));
        vecs.push_back(mk(1,1,5, 1,0,4,0,            0,1,1,0,36,0, 0,0,0,        1,0,PAT+35));
        vecs.push_back(mk(1,1,5, 1,0,5,0,            0,1,1,0,37,0, 0,0,0,        1,0,PAT+36));
        vecs.push_back(mk(1,1,5, 1,0,6,0,            1,0,1,0,5,0,  0,0,0,        1,0,PAT+37));
        vecs.push_back(mk(1,1,5, 1,0,6,0,            0,1,1,0,38,0, 1,0,BEEF,     0,0,0));
        vecs.push_back(mk(1,1,5, 1,0,7,0,            0,1,1,0,39,0, 0,0,0,        1,0,PAT+38));
        vecs.push_back(mk(1,1,5, 1,0,8,0,            0,1,1,0,40,0, 0,0,0,        1,0,PAT+39));
        vecs.push_back(mk(1,1,5, 1,0,9,0,            1,0,1,0,5,0,  0,0,0,        1,0,PAT+40));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  1,0,BEEF,     0,0,0));
        // data write then read-back of d_addr 3 (physical 35)
        vecs.push_back(mk(1,0,0, 1,1,3,32'h12345678, 0,1,1,1,35,32'h12345678, 0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,0, 1,0,3,0,            0,1,1,0,35,0, 0,0,0,        1,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  0,0,0,        1,0,32'h12345678));
        // fetch out of segment, then last legal fetch word
        vecs.push_back(mk(1,1,40, 0,0,0,0,           1,0,0,0,0,0,  0,0,0,        0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  1,1,0,        0,0,0));
        vecs.push_back(mk(1,1,31, 0,0,0,0,           1,0,1,0,31,0, 0,0,0,        0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  1,0,PAT+31,   0,0,0));
        // illegal data write, last legal data word, truncation-sensitive addresses
        vecs.push_back(mk(1,0,0, 1,1,32,32'hCAFEF00D, 0,1,0,0,0,0, 0,0,0,        0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  0,0,0,        1,1,0));
        vecs.push_back(mk(1,0,0, 1,0,31,0,           0,1,1,0,63,0, 0,0,0,        0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  0,0,0,        1,0,PAT+63));
        vecs.push_back(mk(1,0,0, 1,1,64,32'h5,       0,1,0,0,0,0,  0,0,0,        0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  0,0,0,        1,1,0));
        vecs.push_back(mk(1,1,32'h45, 0,0,0,0,       1,0,0,0,0,0,  0,0,0,        0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  1,1,0,        0,0,0));
        // mid-operation reset with starve count at limit
        vecs.push_back(mk(1,1,5, 1,0,0,0,            0,1,1,0,32,0, 0,0,0,        0,0,0));
        vecs.push_back(mk(1,1,5, 1,0,1,0,            0,1,1,0,33,0, 0,0,0,        1,0,PAT+32));
        vecs.push_back(mk(1,1,5, 1,0,2,0,            0,1,1,0,34,0, 0,0,0,        1,0,PAT+33));
        vecs.push_back(mk(0,1,5, 1,0,3,0,            0,0,0,0,0,0,  0,0,0,        0,0,0));
        vecs.push_back(mk(1,1,5, 1,0,3,0,            0,1,1,0,35,0, 0,0,0,        0,0,0));
        vecs.push_back(mk(1,1,5, 1,0,4,0,            0,1,1,0,36,0, 0,0,0,        1,0,32'h12345678));
        vecs.push_back(mk(1,1,5, 0,0,0,0,            1,0,1,0,5,0,  0,0,0,        1,0,PAT+36));
        vecs.push_back(mk(1,0,0, 0,0,0,0,            0,0,0,0,0,0,  1,0,BEEF,     0,0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            $display("row %0d: rst_n=%b if_gnt=%b d_gnt=%b mem_en=%b mem_we=%b mem_addr=%0d if_rv=%b if_err=%b if_rd=%h d_rv=%b d_err=%b d_rd=%h",
                     i, rst_n, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr,
                     bus.if_rvalid, bus.if_err, bus.if_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata);
            chk("if_gnt",    i, 32'(bus.if_gnt),    32'(vecs[i].if_gnt));
            chk("d_gnt",     i, 32'(bus.d_gnt),     32'(vecs[i].d_gnt));
            chk("mem_en",    i, 32'(bus.mem_en),    32'(vecs[i].mem_en));
            chk("mem_we",    i, 32'(bus.mem_we),    32'(vecs[i].mem_we));
            chk("mem_addr",  i, 32'(bus.mem_addr),  32'(vecs[i].mem_addr));
            chk("mem_wd",    i, bus.mem_wd,         vecs[i].mem_wd);
            chk("if_rvalid", i, 32'(bus.if_rvalid), 32'(vecs[i].if_rvalid));
            chk("if_err",    i, 32'(bus.if_err),    32'(vecs[i].if_err));
            chk("if_rdata",  i, bus.if_rdata,       vecs[i].if_rdata);
            chk("d_rvalid",  i, 32'(bus.d_rvalid),  32'(vecs[i].d_rvalid));
            chk("d_err",     i, 32'(bus.d_err),     32'(vecs[i].d_err));
            chk("d_rdata",   i, bus.d_rdata,        vecs[i].d_rdata);
        end

        // back-to-back fetch stream: one grant per cycle, responses pipelined
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst_n = 1'b1; bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'(k + 5);
            #2;
            $display("stream %0d: if_gnt=%b mem_addr=%0d if_rv=%b if_rd=%h",
                     k, bus.if_gnt, bus.mem_addr, bus.if_rvalid, bus.if_rdata);
            chk("stream_gnt",  100 + k, 32'(bus.if_gnt),   32'd1);
            chk("stream_addr", 100 + k, 32'(bus.mem_addr), 32'(k + 5));
            chk("stream_rv",   100 + k, 32'(bus.if_rvalid), (k > 0) ? 32'd1 : 32'd0);
            chk("stream_rd",   100 + k, bus.if_rdata, (k > 0) ? word_at(k + 4) : 32'd0);
        end
        @(negedge clk);
        bus.if_req = 1'b0;
        #2;
        $display("stream end: if_rv=%b if_rd=%h", bus.if_rvalid, bus.if_rdata);
        chk("stream_last_rv", 104, 32'(bus.if_rvalid), 32'd1);
        chk("stream_last_rd", 104, bus.if_rdata, word_at(8));

        // illegal writes must have left memory untouched; legal write landed
        $display("mem check: mem[0]=%h mem[35]=%h", mem[0], mem[35]);
        chk("mem0_unchanged", 200, mem[0],  PAT);
        chk("mem35_written",  200, mem[35], 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter sharing the single-ported, segmented program/data memory between the instruction-fetch stage and the memory (load/store) stage. Accepts one request per cycle, translates segment-relative addresses to physical word addresses (instruction segment at 0, data segment at DATA_BASE), and returns read data one cycle later. Data accesses have priority, with a starvation counter guaranteeing forward progress for fetch.

## Interface
- AW, 6, physical word-address width of the memory (2^AW words)
- DATA_BASE, 32, first physical word of the data segment; instruction segment is [0, DATA_BASE)
- STARVE_LIMIT, 3, consecutive data grants allowed while fetch waits before fetch is forced

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; if_addr held stable until granted
- if_addr  in  32  instruction word index (segment-relative)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetched instruction
- if_err  out  1  fetch address out of segment (with if_rvalid)
- d_req  in  1  data request; d_we/d_addr/d_wd held stable until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data word index (segment-relative)
- d_wd  in  32  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (read data or write acknowledge)
- d_rdata  out  32  read data
- d_err  out  1  data address out of segment (with d_rvalid)
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  AW  physical word address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, valid the cycle after a read with mem_en=1

## Operation
- Transfer = req && gnt in same cycle. At most one of if_gnt/d_gnt per cycle; gnt is combinational from req, starve state, rst_n.
- Priority: d_req wins unless if_req=1 and starve_cnt == STARVE_LIMIT, then fetch wins.
- starve_cnt: +1 (saturating at STARVE_LIMIT) each cycle d is granted while if_req=1; cleared when fetch granted or if_req=0.
- Range check: fetch legal iff if_addr < DATA_BASE; data legal iff d_addr < 2^AW − DATA_BASE (full 32-bit compare, no truncation before compare).
- Legal fetch: mem_en=1, mem_we=0, mem_addr=if_addr[AW-1:0].
- Legal data: mem_en=1, mem_we=d_we, mem_addr=(DATA_BASE + d_addr)[AW-1:0], mem_wd=d_wd.
- Illegal access: still granted (consumes slot), mem_en=0, mem_we=0 (no write); response next cycle with err=1.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wd=0.
- Response regs (rvalid, err, owner) capture the grant; rdata = mem_rd when rvalid && !err && read, else 0. Write ack: d_rvalid=1, d_rdata=0.
- Requests must not be withdrawn before grant; behaviour with unstable request fields is undefined.

## Timing
- Latency: grant in cycle T, memory samples at end of T, response (rvalid, rdata, err) in T+1.
- Back-to-back: one grant every cycle, responses pipelined, no bubbles.
- rst_n low in a cycle: both gnt=0, mem_en=0, mem_we=0; at that edge rvalid/err regs and starve_cnt cleared. In-flight response from the previous cycle is dropped.
- Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_en, mem_we = 0; if_rdata, d_rdata, mem_addr, mem_wd = 0; starve_cnt = 0.
- Simultaneous if_req and d_req with starve_cnt < STARVE_LIMIT: d granted, fetch waits.
- STARVE_LIMIT = 0: fetch always wins on contention.

## Test plan
- Reset: rst_n low 2 cycles with if_req=d_req=1 -> all gnt, rvalid, mem_en 0; after release first grant goes to data.
- Fetch: memory word 5 = 0xDEADBEEF, if_req, if_addr=5 -> if_gnt and mem_addr=5 same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0.
- Data write then read: d_we=1, d_addr=3, d_wd=0x12345678 -> mem_addr=35, mem_we=1, d_rvalid next cycle; read d_addr=3 -> d_rdata=0x12345678.
- Contention: if_req and d_req held high for 12 cycles, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I,D,D,D,I; responses each follow by one cycle.
- Range errors: if_addr=40 -> if_gnt, mem_en=0, next cycle if_rvalid=1, if_err=1, if_rdata=0; d_we=1, d_addr=32 -> d_gnt, mem_we=0, d_err=1, memory unchanged.
- Mid-operation reset: starve_cnt at 3 with both requesting, rst_n low one cycle -> no grant that cycle, no rvalid next cycle, first grant after reset to data.
